// File: rtl/io_bus_responder.sv
// Memory-mapped KEY/SW/HEX/LEDR/LEDG responder; reads are combinational and writes take effect at the next edge.
// Inputs see 2 sync cycles plus DEBOUNCE_CYCLES of stability; no backpressure (hit flags a decoded address).
module io_bus_responder #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter int               DB_CNT_BITS     = 18
) (
    input  logic             CLOCK_50,
    input  logic             FPGA_RESET_N,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrData,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rdData,
    output logic             hit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    localparam logic [DB_CNT_BITS-1:0] DB_LAST = DB_CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [15:0] hex_q, hex_d;
    logic [9:0]  ledr_q, ledr_d;
    logic [7:0]  ledg_q, ledg_d;

    logic [3:0]  key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [3:0]  key_db_q, key_db_d, key_stk_q, key_stk_d;
    logic [DB_CNT_BITS-1:0] key_cnt_q [4];
    logic [DB_CNT_BITS-1:0] key_cnt_d [4];
    logic [3:0]  key_rise, key_clr;

    logic [9:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sw_s3_q, sw_s3_d;
    logic [9:0]  sw_db_q, sw_db_d;
    logic        sw_chg_q, sw_chg_d, sw_set, sw_clr;
    logic [DB_CNT_BITS-1:0] sw_cnt_q, sw_cnt_d;

    logic sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw;

    // re is part of the bus contract only; upper store bits are never used
    logic unused_bus;
    assign unused_bus = ^{re, wrData[DBITS-1:16]};

    assign sel_hex  = (addr == ADDR_HEX);
    assign sel_ledr = (addr == ADDR_LEDR);
    assign sel_ledg = (addr == ADDR_LEDG);
    assign sel_key  = (addr == ADDR_KEY);
    assign sel_sw   = (addr == ADDR_SW);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        hex_d     = hex_q;
        ledr_d    = ledr_q;
        ledg_d    = ledg_q;
        key_s1_d  = ~KEY;
        key_s2_d  = key_s1_q;
        key_db_d  = key_db_q;
        key_cnt_d = key_cnt_q;
        sw_s1_d   = SW;
        sw_s2_d   = sw_s1_q;
        sw_s3_d   = sw_s2_q;
        sw_db_d   = sw_db_q;
        sw_cnt_d  = sw_cnt_q;
        sw_set    = 1'b0;

        if (we && sel_hex)  hex_d  = wrData[15:0];
        if (we && sel_ledr) ledr_d = wrData[9:0];
        if (we && sel_ledg) ledg_d = wrData[7:0];

        for (int i = 0; i < 4; i++) begin
            if (key_s2_q[i] != key_db_q[i]) begin
                if (key_cnt_q[i] == DB_LAST) begin
                    key_db_d[i]  = key_s2_q[i];
                    key_cnt_d[i] = '0;
                end else begin
                    key_cnt_d[i] = key_cnt_q[i] + 1'b1;
                end
            end else begin
                key_cnt_d[i] = '0;
            end
        end

        // a new pending switch pattern (sync differs from last cycle) restarts the count
        if (sw_s2_q != sw_db_q) begin
            if (sw_s2_q != sw_s3_q) begin
                sw_cnt_d = '0;
            end else if (sw_cnt_q == DB_LAST) begin
                sw_db_d  = sw_s2_q;
                sw_cnt_d = '0;
                sw_set   = 1'b1;
            end else begin
                sw_cnt_d = sw_cnt_q + 1'b1;
            end
        end else begin
            sw_cnt_d = '0;
        end

        key_rise  = key_db_d & ~key_db_q;
        key_clr   = (we && sel_key) ? wrData[7:4] : 4'b0;
        key_stk_d = (key_stk_q & ~key_clr) | key_rise;
        sw_clr    = we && sel_sw && wrData[10];
        sw_chg_d  = (sw_chg_q & ~sw_clr) | sw_set;
    end

    always_ff @(posedge CLOCK_50) begin
        if (FPGA_RESET_N) begin
            hex_q     <= '0;
            ledr_q    <= '0;
            ledg_q    <= '0;
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            key_db_q  <= '0;
            key_stk_q <= '0;
            for (int i = 0; i < 4; i++) key_cnt_q[i] <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_s3_q   <= '0;
            sw_db_q   <= '0;
            sw_chg_q  <= 1'b0;
            sw_cnt_q  <= '0;
        end else begin
            hex_q     <= hex_d;
            ledr_q    <= ledr_d;
            ledg_q    <= ledg_d;
            key_s1_q  <= key_s1_d;
            key_s2_q  <= key_s2_d;
            key_db_q  <= key_db_d;
            key_stk_q <= key_stk_d;
            key_cnt_q <= key_cnt_d;
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            sw_s3_q   <= sw_s3_d;
            sw_db_q   <= sw_db_d;
            sw_chg_q  <= sw_chg_d;
            sw_cnt_q  <= sw_cnt_d;
        end
    end

    always_comb begin
        rdData = '0;
        hit    = 1'b1;
        if (sel_hex)       rdData[15:0] = hex_q;
        else if (sel_ledr) rdData[9:0]  = ledr_q;
        else if (sel_ledg) rdData[7:0]  = ledg_q;
        else if (sel_key)  rdData[7:0]  = {key_stk_q, key_db_q};
        else if (sel_sw)   rdData[10:0] = {sw_chg_q, sw_db_q};
        else               hit          = 1'b0;
    end

    assign LEDR = ledr_q;
    assign LEDG = ledg_q;
    assign HEX0 = seg7(hex_q[3:0]);
    assign HEX1 = seg7(hex_q[7:4]);
    assign HEX2 = seg7(hex_q[11:8]);
    assign HEX3 = seg7(hex_q[15:12]);

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder with a 4-cycle debounce; expected read data is queued
// when a load is issued and popped when the combinational response is sampled.
module tb_io_bus_responder;

    localparam logic [31:0] A_HEX  = 32'hF0000000;
    localparam logic [31:0] A_LEDR = 32'hF0000004;
    localparam logic [31:0] A_LEDG = 32'hF0000008;
    localparam logic [31:0] A_KEY  = 32'hF0000010;
    localparam logic [31:0] A_SW   = 32'hF0000014;
    localparam logic [31:0] A_NONE = 32'hF000000C;

    logic        CLOCK_50 = 1'b0;
    logic        FPGA_RESET_N = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wrData = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdData;
    logic        hit;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic        exp_hit_q[$];
    string       tag_q[$];

    io_bus_responder #(
        .DEBOUNCE_CYCLES(4),
        .DB_CNT_BITS    (3)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .FPGA_RESET_N(FPGA_RESET_N),
        .addr        (addr),
        .wrData      (wrData),
        .we          (we),
        .re          (re),
        .rdData      (rdData),
        .hit         (hit),
        .KEY         (KEY),
        .SW          (SW),
        .LEDR        (LEDR),
        .LEDG        (LEDG),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // issue a load and score the combinational response 1 time unit later
    task automatic expect_read(input logic [31:0] a, input logic [31:0] v,
                               input logic h, input string tag);
        addr = a;
        exp_q.push_back(v);
        exp_hit_q.push_back(h);
        tag_q.push_back(tag);
        #1;
        begin
            string t;
            t = tag_q.pop_front();
            check(t, rdData, exp_q.pop_front());
            check({t, "_hit"}, 32'(hit), 32'(exp_hit_q.pop_front()));
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLOCK_50);
        addr = a; wrData = d; we = 1'b1;
        @(negedge CLOCK_50);
        we = 1'b0; wrData = '0;
    endtask

    initial begin
        bit got_sw;
        re = 1'b1;
        tick(3);
        FPGA_RESET_N = 1'b0;

        expect_read(A_HEX,  32'h0, 1'b1, "rst_hex");
        expect_read(A_LEDR, 32'h0, 1'b1, "rst_ledr");
        expect_read(A_LEDG, 32'h0, 1'b1, "rst_ledg");
        expect_read(A_KEY,  32'h0, 1'b1, "rst_key");
        expect_read(A_SW,   32'h0, 1'b1, "rst_sw");
        check("rst_hex0", 32'(HEX0), 32'h40);
        check("rst_hex3", 32'(HEX3), 32'h40);
        check("rst_ledr_pin", 32'(LEDR), 32'h0);
        check("rst_ledg_pin", 32'(LEDG), 32'h0);

        bus_write(A_HEX,  32'h0000_3A7F);
        bus_write(A_LEDR, 32'hFFFF_FFFF);
        bus_write(A_LEDG, 32'hFFFF_FFFF);
        check("hex3_3", 32'(HEX3), 32'h30);
        check("hex2_A", 32'(HEX2), 32'h08);
        check("hex1_7", 32'(HEX1), 32'h78);
        check("hex0_F", 32'(HEX0), 32'h0E);
        check("ledr_pin", 32'(LEDR), 32'h3FF);
        check("ledg_pin", 32'(LEDG), 32'hFF);
        expect_read(A_LEDR, 32'h3FF,  1'b1, "rd_ledr");
        expect_read(A_LEDG, 32'hFF,   1'b1, "rd_ledg");
        expect_read(A_HEX,  32'h3A7F, 1'b1, "rd_hex");
        expect_read(A_NONE, 32'h0,    1'b0, "rd_unmapped");
        bus_write(A_NONE, 32'h0000_FFFF);
        expect_read(A_HEX,  32'h3A7F, 1'b1, "hex_after_unmapped_wr");

        // 3-cycle glitch must be rejected
        tick(1); KEY[1] = 1'b0;
        tick(3); KEY[1] = 1'b1;
        tick(8);
        expect_read(A_KEY, 32'h00, 1'b1, "key_glitch");

        // held press accepted after 2 sync + 4 stable cycles
        tick(1); KEY[1] = 1'b0;
        tick(5);
        expect_read(A_KEY, 32'h00, 1'b1, "key_press_early");
        tick(1);
        expect_read(A_KEY, 32'h22, 1'b1, "key_press");
        KEY[1] = 1'b1;
        tick(6);
        expect_read(A_KEY, 32'h20, 1'b1, "key_release");
        bus_write(A_KEY, 32'h20);
        expect_read(A_KEY, 32'h00, 1'b1, "key_w1c");

        // clear on the same edge keyDb[0] rises: set wins
        tick(1); KEY[0] = 1'b0;
        tick(5);
        addr = A_KEY; wrData = 32'h10; we = 1'b1;
        tick(1);
        we = 1'b0; wrData = '0;
        expect_read(A_KEY, 32'h11, 1'b1, "key_set_wins");
        bus_write(A_KEY, 32'h10);
        expect_read(A_KEY, 32'h01, 1'b1, "key_clr0");
        KEY[0] = 1'b1;
        tick(8);
        expect_read(A_KEY, 32'h00, 1'b1, "key_rel0");

        // switch bounce then settle on 0x155
        tick(1); SW = 10'h3FF;
        tick(2); SW = 10'h000;
        tick(2); SW = 10'h155;
        tick(3);
        expect_read(A_SW, 32'h000, 1'b1, "sw_not_yet");
        got_sw = 1'b0;
        for (int i = 0; i < 12 && !got_sw; i++) begin
            tick(1);
            addr = A_SW;
            #1;
            if (rdData == 32'h555) got_sw = 1'b1;
        end
        check("sw_settle", 32'(got_sw), 32'h1);
        re = 1'b0;
        expect_read(A_SW, 32'h555, 1'b1, "sw_chg");
        re = 1'b1;
        bus_write(A_SW, 32'h400);
        expect_read(A_SW, 32'h155, 1'b1, "sw_w1c");

        // reset in the middle of a key debounce
        tick(1); KEY[2] = 1'b0;
        tick(3); FPGA_RESET_N = 1'b1;
        tick(1); FPGA_RESET_N = 1'b0;
        check("mid_rst_hex0", 32'(HEX0), 32'h40);
        check("mid_rst_ledr", 32'(LEDR), 32'h0);
        check("mid_rst_ledg", 32'(LEDG), 32'h0);
        expect_read(A_KEY, 32'h0, 1'b1, "mid_rst_key");
        expect_read(A_SW,  32'h0, 1'b1, "mid_rst_sw");
        expect_read(A_HEX, 32'h0, 1'b1, "mid_rst_hexreg");
        tick(5);
        expect_read(A_KEY, 32'h00, 1'b1, "post_rst_early");
        tick(1);
        expect_read(A_KEY, 32'h44, 1'b1, "post_rst_press");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Memory-mapped I/O responder on the processor data bus.
- Decodes the KEY, SW, HEX, LEDR and LEDG addresses. Returns read data combinationally, so a single-cycle CPU can use it.
- Holds the output registers for HEX, LEDR and LEDG.
- Synchronizes and debounces KEY and SW, and keeps sticky event bits the CPU can poll and clear.

Parameters:
- DBITS, 32, bus data and address width.
- ADDR_HEX, 32'hF0000000, HEX digit register.
- ADDR_LEDR, 32'hF0000004, red LED register.
- ADDR_LEDG, 32'hF0000008, green LED register.
- ADDR_KEY, 32'hF0000010, key status and sticky register.
- ADDR_SW, 32'hF0000014, switch status register.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new input level (5 ms at 50 MHz).
- DB_CNT_BITS, 18, debounce counter width; must satisfy 2^DB_CNT_BITS > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- FPGA_RESET_N  in  1  reset; synchronous, active-high (1 = reset) despite the name.
- addr  in  DBITS  bus address, word-aligned exact match.
- wrData  in  DBITS  store data.
- we  in  1  store strobe, sampled at the clock edge.
- re  in  1  load strobe.
- rdData  out  DBITS  load data, combinational.
- hit  out  1  addr matches one of the five registers.
- KEY  in  4  raw pushbuttons, active-low.
- SW  in  10  raw switches.
- LEDR  out  10  red LEDs.
- LEDG  out  8  green LEDs.
- HEX0..HEX3  out  7 each  active-low seven-segment outputs, segment order gfedcba.

Behaviour:
- Reset (FPGA_RESET_N=1 at an edge):
  - hexReg=0 and HEX0..3 show "0" (7'b1000000).
  - LEDR=0, LEDG=0.
  - keyDb=0 (released), keySticky=0, swDb=0, swChg=0.
  - All synchronizer flops load 0; synchronizer KEY flops load the inverted released level.
  - All debounce counters = 0.
  - Reset overrides any write, debounce event or sticky set in the same cycle.
- Synchronizer: KEY inverted (pressed=1) and SW each pass two flops. Raw-to-sync latency is 2 cycles.
- Key debounce, one counter per bit:
  - If sync bit != keyDb bit, counter increments.
  - If equal, counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing: keyDb bit takes the sync value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves keyDb unchanged.
- Key sticky: keySticky[i] sets on the cycle keyDb[i] goes 0 to 1 (press). Release does not set it.
- Switch debounce: one shared counter over the 10-bit vector.
  - Counter increments while sync != swDb and clears when equal.
  - If the sync value changes between two non-equal values, the counter restarts at 0.
  - On terminal count, swDb takes the whole vector and swChg sets.
- Reads (combinational from addr, independent of re; re exists only for the bus contract):
  - ADDR_KEY: {24'b0, keySticky[3:0], keyDb[3:0]}.
  - ADDR_SW: {21'b0, swChg, swDb[9:0]}.
  - ADDR_HEX: {16'b0, hexReg}.
  - ADDR_LEDR: {22'b0, LEDR}.
  - ADDR_LEDG: {24'b0, LEDG}.
  - Unmapped address: rdData=0, hit=0.
- Writes (we=1 at an edge, mapped address):
  - HEX: hexReg ← wrData[15:0].
  - LEDR: LEDR ← wrData[9:0].
  - LEDG: LEDG ← wrData[7:0].
  - KEY: write-1-to-clear keySticky using wrData[7:4]; bits [3:0] ignored.
  - SW: write-1-to-clear swChg using wrData[10].
  - Upper bits are ignored in every case. Writes to an unmapped address have no effect.
  - Written values appear on outputs and reads in the next cycle.
- Simultaneous sticky clear and set in the same cycle: set wins and the bit stays 1.
- Read during the same cycle as a write to that address returns the old value.
- Reset mid-debounce discards the count; the input must then be stable DEBOUNCE_CYCLES cycles after reset.
- Seven-segment decode is combinational, per nibble (HEX0 = hexReg[3:0]). It covers 0–F with standard active-low glyphs, e.g. 0 = 7'b1000000, 1 = 7'b1111001, A = 7'b0001000, F = 7'b0001110.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then read all five addresses -> all return 0. HEX0..3 = 7'b1000000. LEDR=0, LEDG=0.
- Store 0x0000_3A7F to ADDR_HEX; store 0xFFFF_FFFF to ADDR_LEDR and ADDR_LEDG -> HEX3..0 show 3, A, 7, F. LEDR=10'h3FF, LEDG=8'hFF. ADDR_LEDR reads 0x3FF. Address 0xF000000C reads 0 with hit=0.
- Drive KEY[1]=0 for 3 cycles, then release -> ADDR_KEY stays 0x00.
- Hold KEY[1]=0 -> after 2 sync + 4 stable cycles, ADDR_KEY = 0x22. Release and wait 6 cycles -> 0x20. Store 0x20 to ADDR_KEY -> 0x00.
- Store 0x10 to ADDR_KEY in the same cycle keyDb[0] rises -> keySticky[0]=1 (set wins). Read = 0x11.
- SW toggles 0x3FF to 0x000 to 0x155, changing every 2 cycles, then holds -> swDb updates only after 0x155 has been stable 4 cycles. ADDR_SW = 0x555. Store 0x400 -> reads 0x155.
- Assert reset while a KEY debounce count is mid-way -> state clears to reset values. A new press needs the full 4 stable cycles.
